// File: rtl/aes_package.sv
// Shared types and constants for the AES HWPE: streamer/engine control and
// status records, controller state encoding and the latched job descriptor.
package aes_package;

  localparam int AES_ADDR_W      = 32;
  localparam int AES_BLOCK_BYTES = 32;
  localparam int AES_MAX_BLOCKS  = 256;
  localparam int AES_NBLK_W      = $clog2(AES_MAX_BLOCKS) + 1;

  typedef enum logic [1:0] {
    AES_IDLE,
    AES_STARTING,
    AES_WORKING,
    AES_FINISHED
  } aes_state_t;

  typedef struct packed {
    logic [31:0] base_addr;
    logic [31:0] trans_size;
    logic [15:0] line_stride;
    logic [15:0] line_length;
    logic [15:0] feat_stride;
    logic [15:0] feat_length;
    logic [15:0] loop_outer;
    logic        realign_type;
  } addressgen_ctrl_t;

  typedef struct packed {
    logic             req_start;
    addressgen_ctrl_t addressgen_ctrl;
  } ctrl_sourcesink_t;

  typedef struct packed {
    logic ready_start;
    logic done;
  } flags_sourcesink_t;

  typedef struct packed {
    ctrl_sourcesink_t plaintext_source_ctrl;
    ctrl_sourcesink_t chipertext_sink_ctrl;
  } ctrl_streamer_t;

  typedef struct packed {
    flags_sourcesink_t plaintext_source_flags;
    flags_sourcesink_t chipertext_sink_flags;
    logic              tcdm_fifo_empty;
  } flags_streamer_t;

  typedef struct packed {
    logic clear;
    logic enable;
    logic start;
  } ctrl_engine_t;

  typedef struct packed {
    logic [AES_NBLK_W-1:0] chipertext_32byte_chunck_count;
  } flags_engine_t;

  typedef struct packed {
    logic [AES_ADDR_W-1:0] addr_in;
    logic [AES_ADDR_W-1:0] addr_out;
    logic [AES_NBLK_W-1:0] nblocks;
  } aes_job_cfg_t;

  // One linear transfer of nblocks 256-bit blocks, counted in 32-bit words.
  function automatic addressgen_ctrl_t agen_linear(input logic [AES_ADDR_W-1:0] base,
                                                   input logic [AES_NBLK_W-1:0] nblocks);
    addressgen_ctrl_t cfg;
    logic [31:0]      words;
    words            = 32'(nblocks) * 32'(AES_BLOCK_BYTES / 4);
    cfg              = '0;
    cfg.base_addr    = base;
    cfg.trans_size   = words;
    cfg.line_length  = words[15:0];
    cfg.feat_length  = 16'd1;
    return cfg;
  endfunction

endpackage

// File: rtl/aes_ctrl_fsm.sv
// AES HWPE sequencer: validates the programmed job, launches the source/sink
// streamers and the engine, and reports completion or rejection as pulses.
module aes_ctrl_fsm
  import aes_package::*;
#(
  parameter int ADDR_W      = AES_ADDR_W,
  parameter int BLOCK_BYTES = AES_BLOCK_BYTES,
  parameter int MAX_BLOCKS  = AES_MAX_BLOCKS
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] addr_in_i,
  input  logic [ADDR_W-1:0] addr_out_i,
  input  logic [ADDR_W-1:0] length_i,
  input  flags_streamer_t   flags_streamer_i,
  input  flags_engine_t     flags_engine_i,
  output ctrl_streamer_t    ctrl_streamer_o,
  output ctrl_engine_t      ctrl_engine_o,
  output aes_state_t        state_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int OFS_W = $clog2(BLOCK_BYTES);

  aes_state_t   state_q, state_d;
  aes_job_cfg_t cfg_q, cfg_d;
  logic         sink_done_q, sink_done_d;

  logic                  len_ok;
  logic [AES_NBLK_W-1:0] len_nblk;
  logic                  both_ready, sink_done_now, job_complete;
  logic                  req_start, eng_clear, eng_enable, eng_start;
  logic                  unused_src_done;

  assign len_nblk = length_i[OFS_W +: AES_NBLK_W];
  assign len_ok   = (length_i != '0) && (length_i[OFS_W-1:0] == '0)
                 && ((length_i >> OFS_W) <= ADDR_W'(MAX_BLOCKS));

  assign both_ready    = flags_streamer_i.plaintext_source_flags.ready_start
                      && flags_streamer_i.chipertext_sink_flags.ready_start;
  assign sink_done_now = flags_streamer_i.chipertext_sink_flags.done;
  // The sink done flag is a pulse, so it may precede the last engine block.
  assign job_complete  = (flags_engine_i.chipertext_32byte_chunck_count == cfg_q.nblocks)
                      && (sink_done_q || sink_done_now)
                      && flags_streamer_i.tcdm_fifo_empty;

  assign unused_src_done = flags_streamer_i.plaintext_source_flags.done;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= AES_IDLE;
      cfg_q       <= '0;
      sink_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      sink_done_q <= sink_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    sink_done_d = sink_done_q;
    req_start   = 1'b0;
    eng_clear   = 1'b0;
    eng_enable  = 1'b0;
    eng_start   = 1'b0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    if (clear_i) begin
      state_d     = AES_IDLE;
      cfg_d       = '0;
      sink_done_d = 1'b0;
      eng_clear   = 1'b1;
    end else begin
      unique case (state_q)
        AES_IDLE: begin
          if (start_i) begin
            if (len_ok) begin
              cfg_d.addr_in  = addr_in_i;
              cfg_d.addr_out = addr_out_i;
              cfg_d.nblocks  = len_nblk;
              eng_clear      = 1'b1;
              state_d        = AES_STARTING;
            end else begin
              err_o = 1'b1;
            end
          end
        end
        AES_STARTING: begin
          if (both_ready) begin
            req_start = 1'b1;
            eng_start = 1'b1;
            state_d   = AES_WORKING;
          end
        end
        AES_WORKING: begin
          eng_enable = 1'b1;
          if (sink_done_now) sink_done_d = 1'b1;
          if (job_complete) state_d = AES_FINISHED;
        end
        AES_FINISHED: begin
          done_o      = 1'b1;
          sink_done_d = 1'b0;
          state_d     = AES_IDLE;
        end
        default: state_d = AES_IDLE;
      endcase
    end
  end

  // Addressgen configs are only presented while a job is in flight.
  always_comb begin
    ctrl_streamer_o = '0;
    if (state_q != AES_IDLE) begin
      ctrl_streamer_o.plaintext_source_ctrl.addressgen_ctrl = agen_linear(cfg_q.addr_in, cfg_q.nblocks);
      ctrl_streamer_o.chipertext_sink_ctrl.addressgen_ctrl  = agen_linear(cfg_q.addr_out, cfg_q.nblocks);
    end
    ctrl_streamer_o.plaintext_source_ctrl.req_start = req_start;
    ctrl_streamer_o.chipertext_sink_ctrl.req_start  = req_start;
  end

  always_comb begin
    ctrl_engine_o        = '0;
    ctrl_engine_o.clear  = eng_clear;
    ctrl_engine_o.enable = eng_enable;
    ctrl_engine_o.start  = eng_start;
  end

  assign state_o = state_q;
  assign busy_o  = (state_q != AES_IDLE);

endmodule

// File: tb/tb_aes_ctrl_fsm.sv
// Scoreboard bench for aes_ctrl_fsm: the driver plays streamers and engine and
// queues the expected clear/err/start/done pulses; a monitor checks them.
module tb_aes_ctrl_fsm;
  import aes_package::*;

  localparam int EV_CLR = 0, EV_ERR = 1, EV_START = 2, EV_DONE = 3;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] a_in;
    logic [31:0] a_out;
    logic [31:0] words;
  } ev_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clear_i = 1'b0;
  logic            start_i = 1'b0;
  logic [31:0]     addr_in = '0, addr_out = '0, length_i = '0;
  flags_streamer_t fs;
  flags_engine_t   fe;
  ctrl_streamer_t  cs;
  ctrl_engine_t    ce;
  aes_state_t      st;
  logic            busy, done, err;

  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  ev_t q[$];

  aes_ctrl_fsm dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .clear_i          (clear_i),
    .start_i          (start_i),
    .addr_in_i        (addr_in),
    .addr_out_i       (addr_out),
    .length_i         (length_i),
    .flags_streamer_i (fs),
    .flags_engine_i   (fe),
    .ctrl_streamer_o  (cs),
    .ctrl_engine_o    (ce),
    .state_o          (st),
    .busy_o           (busy),
    .done_o           (done),
    .err_o            (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string ev_name(input int kind);
    case (kind)
      EV_CLR:   return "engine_clear";
      EV_ERR:   return "err";
      EV_START: return "start";
      default:  return "done";
    endcase
  endfunction

  // Reference rule for job acceptance, in plain arithmetic.
  function automatic bit len_valid(input logic [31:0] len);
    return (len != 0) && (len % 32 == 0) && (len / 32 <= 256);
  endfunction

  task automatic push_ev(input int kind, input logic [31:0] ain, input logic [31:0] aout,
                         input logic [31:0] words);
    ev_t e;
    e.kind = kind; e.cyc = cyc; e.a_in = ain; e.a_out = aout; e.words = words;
    q.push_back(e);
  endtask

  task automatic expect_ev(input int kind);
    ev_t              e;
    addressgen_ctrl_t s, k;
    checks++;
    if (q.size() == 0 || q[0].cyc > cyc) begin
      failures++;
      $display("FAIL unexpected_%s: actual pulse at cycle %0d, required none", ev_name(kind), cyc);
      return;
    end
    e = q[0];
    q.delete(0);
    if (e.kind != kind || e.cyc != cyc) begin
      failures++;
      $display("FAIL event_order: actual %s@%0d, required %s@%0d",
               ev_name(kind), cyc, ev_name(e.kind), e.cyc);
    end else if (kind == EV_START) begin
      s = cs.plaintext_source_ctrl.addressgen_ctrl;
      k = cs.chipertext_sink_ctrl.addressgen_ctrl;
      if (!(s.base_addr == e.a_in && k.base_addr == e.a_out &&
            s.trans_size == e.words && k.trans_size == e.words &&
            32'(s.line_length) == e.words && 32'(k.line_length) == e.words &&
            s.feat_length == 16'd1 && k.feat_length == 16'd1 &&
            s.line_stride == 0 && k.line_stride == 0 && s.feat_stride == 0 && k.feat_stride == 0 &&
            s.loop_outer == 0 && k.loop_outer == 0 && !s.realign_type && !k.realign_type &&
            cs.plaintext_source_ctrl.req_start && cs.chipertext_sink_ctrl.req_start && ce.start)) begin
        failures++;
        $display("FAIL start_cfg: actual src=0x%0h sink=0x%0h trans=%0d/%0d line=%0d/%0d req=%b%b eng=%b, required src=0x%0h sink=0x%0h trans=%0d all pulses 1",
                 s.base_addr, k.base_addr, s.trans_size, k.trans_size, s.line_length, k.line_length,
                 cs.plaintext_source_ctrl.req_start, cs.chipertext_sink_ctrl.req_start, ce.start,
                 e.a_in, e.a_out, e.words);
      end
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      checks++;
      failures++;
      $display("FAIL missing_%s: actual none by cycle %0d, required at cycle %0d",
               ev_name(q[0].kind), cyc, q[0].cyc);
      q.delete(0);
    end
    if (rst_n) begin
      if (ce.clear) expect_ev(EV_CLR);
      if (err) expect_ev(EV_ERR);
      if (cs.plaintext_source_ctrl.req_start || cs.chipertext_sink_ctrl.req_start || ce.start)
        expect_ev(EV_START);
      if (done) expect_ev(EV_DONE);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    start_i = 1'b0;
    clear_i = 1'b0;
    fs.chipertext_sink_flags.done  = 1'b0;
    fs.plaintext_source_flags.done = 1'b0;
  endtask

  // Random commands while busy; all must be ignored silently.
  task automatic noise();
    start_i  = ($urandom_range(0, 2) == 0);
    length_i = $urandom();
    addr_in  = $urandom();
    addr_out = $urandom();
  endtask

  task automatic bad_job(input logic [31:0] len);
    step();
    start_i = 1'b1; length_i = len; addr_in = $urandom(); addr_out = $urandom();
    fs.plaintext_source_flags.ready_start = 1'b1;
    fs.chipertext_sink_flags.ready_start  = 1'b1;
    push_ev(EV_ERR, 0, 0, 0);
    step();
    chk("idle_after_err", 32'(st), 32'(AES_IDLE));
    chk("busy_after_err", 32'(busy), 0);
  endtask

  // d: cycles of sink not ready; t_*: cycles into WORKING at which the engine
  // count reaches nblocks, the sink done pulse comes, the fifo drains; clr_t<0: no abort.
  task automatic run_job(input logic [31:0] len, input logic [31:0] ain, input logic [31:0] aout,
                         input int d, input int t_cnt, input int t_sd, input int t_fe, input int clr_t);
    int nb, tmax;
    nb   = int'(len / 32);
    tmax = t_cnt;
    if (t_sd > tmax) tmax = t_sd;
    if (t_fe > tmax) tmax = t_fe;
    step();
    start_i = 1'b1; length_i = len; addr_in = ain; addr_out = aout;
    fs.tcdm_fifo_empty = 1'b0;
    fe.chipertext_32byte_chunck_count = '0;
    fs.plaintext_source_flags.ready_start = 1'b1;
    fs.chipertext_sink_flags.ready_start  = (d == 0);
    push_ev(EV_CLR, 0, 0, 0);
    for (int i = 0; i < d; i++) begin
      step();
      chk("starting_hold", 32'(st), 32'(AES_STARTING));
      noise();
      fs.plaintext_source_flags.ready_start = 1'($urandom_range(0, 1));
      fs.chipertext_sink_flags.ready_start  = 1'b0;
    end
    step();
    chk("starting_state", 32'(st), 32'(AES_STARTING));
    noise();
    fs.plaintext_source_flags.ready_start = 1'b1;
    fs.chipertext_sink_flags.ready_start  = 1'b1;
    push_ev(EV_START, ain, aout, len / 4);
    for (int t = 0; t <= tmax; t++) begin
      step();
      if (t == 0) chk("working_state", 32'(st), 32'(AES_WORKING));
      noise();
      fs.plaintext_source_flags.ready_start = 1'($urandom_range(0, 1));
      fs.chipertext_sink_flags.ready_start  = 1'($urandom_range(0, 1));
      fe.chipertext_32byte_chunck_count = (t >= t_cnt) ? 9'(nb) : 9'($urandom_range(0, nb - 1));
      fs.chipertext_sink_flags.done = (t == t_sd);
      fs.tcdm_fifo_empty = (t >= t_fe);
      if (t == clr_t) begin
        clear_i = 1'b1;
        push_ev(EV_CLR, 0, 0, 0);
        step();
        chk("idle_after_clear", 32'(st), 32'(AES_IDLE));
        chk("cfg_zero_after_clear", cs.plaintext_source_ctrl.addressgen_ctrl.base_addr, 0);
        fe.chipertext_32byte_chunck_count = '0;
        fs.tcdm_fifo_empty = 1'b1;
        return;
      end
    end
    step();
    chk("finished_state", 32'(st), 32'(AES_FINISHED));
    noise();
    push_ev(EV_DONE, 0, 0, 0);
    step();
    chk("busy_after_done", 32'(busy), 0);
    fe.chipertext_32byte_chunck_count = '0;
    fs.tcdm_fifo_empty = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual time limit hit, required bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] len;
    int          sel, t_cnt, t_sd, t_fe, tmax, clr;
    fs = '0;
    fe = '0;
    fs.tcdm_fifo_empty = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 32'(st), 32'(AES_IDLE));
    chk("reset_busy", 32'(busy), 0);
    chk("reset_pulses", {29'd0, done, err, 1'b0}, 0);
    chk("reset_streamer", 32'(cs == '0), 1);
    chk("reset_engine", 32'(ce), 0);
    rst_n = 1'b1;

    run_job(64, 32'h1000, 32'h2000, 0, 1, 0, 1, -1);
    bad_job(0);
    bad_job(33);
    bad_job(8224);
    run_job(96, 32'h3000, 32'h3800, 5, 0, 1, 0, -1);
    run_job(128, 32'h4000, 32'h5000, 0, 3, 0, 5, -1);
    run_job(320, 32'h6000, 32'h7000, 1, 4, 2, 3, 2);
    run_job(32, 32'h0100, 32'h0200, 0, 0, 0, 0, -1);
    run_job(8192, 32'h8000_0000, 32'h9000_0000, 2, 1, 1, 1, -1);

    // Clear and a valid start together: the job is dropped.
    step();
    start_i = 1'b1; length_i = 64; clear_i = 1'b1;
    push_ev(EV_CLR, 0, 0, 0);
    step();
    chk("clear_beats_start", 32'(st), 32'(AES_IDLE));

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       len = 32 * $urandom_range(1, 256);
        1:       len = $urandom_range(0, 9000);
        2:       len = 32 * $urandom_range(257, 400);
        default: len = 32 * $urandom_range(1, 8);
      endcase
      if (len_valid(len)) begin
        t_cnt = $urandom_range(0, 5);
        t_sd  = $urandom_range(0, 5);
        t_fe  = $urandom_range(0, 5);
        tmax  = t_cnt;
        if (t_sd > tmax) tmax = t_sd;
        if (t_fe > tmax) tmax = t_fe;
        clr = ($urandom_range(0, 4) == 0) ? $urandom_range(0, tmax) : -1;
        run_job(len, $urandom(), $urandom(), $urandom_range(0, 4), t_cnt, t_sd, t_fe, clr);
      end else begin
        bad_job(len);
      end
    end

    // Asynchronous reset in the middle of a job.
    step();
    start_i = 1'b1; length_i = 96; addr_in = 32'hA000; addr_out = 32'hB000;
    fs.plaintext_source_flags.ready_start = 1'b1;
    fs.chipertext_sink_flags.ready_start  = 1'b1;
    fs.tcdm_fifo_empty = 1'b0;
    push_ev(EV_CLR, 0, 0, 0);
    step();
    push_ev(EV_START, 32'hA000, 32'hB000, 24);
    step();
    step();
    chk("working_before_reset", 32'(st), 32'(AES_WORKING));
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_state", 32'(st), 32'(AES_IDLE));
    chk("async_reset_busy", 32'(busy), 0);
    chk("async_reset_streamer", 32'(cs == '0), 1);
    chk("async_reset_engine", 32'(ce), 0);
    chk("async_reset_pulses", {30'd0, done, err}, 0);
    step();
    step();
    rst_n = 1'b1;
    fs.tcdm_fifo_empty = 1'b1;
    step();
    chk("idle_after_reset", 32'(st), 32'(AES_IDLE));
    step();
    chk("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_ctrl_fsm.md
Name: aes_ctrl_fsm

Overview:
- Top-level sequencer for the AES HWPE.
- Takes the job programmed in the register file (input address, output address, byte length) and validates it.
- Configures and launches the plaintext source and ciphertext sink streamers, starts the AES engine, and tracks completion through the engine and streamer flags.
- Sits between the register-file/slave unit and the streamer + engine pair; emits a one-cycle done event for the event unit.

Parameters:
- ADDR_W, 32, width of TCDM byte addresses and of the length register
- BLOCK_BYTES, 32, bytes per 256-bit AES block
- MAX_BLOCKS, 256, largest block count per job; equals AES_BLOCK_LENGTH

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- clear_i  in  1  synchronous soft clear / abort
- start_i  in  1  one-cycle job trigger from the register file
- addr_in_i  in  ADDR_W  plaintext base address (AES_REG_ENCRYPT_START_ADDR_IN)
- addr_out_i  in  ADDR_W  ciphertext base address (AES_REG_ENCRYPT_START_ADDR_OUT)
- length_i  in  ADDR_W  job length in bytes (AES_REG_ENCRYPT_LENGTH)
- flags_streamer_i  in  flags_streamer_t  streamer status
- flags_engine_i  in  flags_engine_t  engine status
- ctrl_streamer_o  out  ctrl_streamer_t  streamer configuration and start
- ctrl_engine_o  out  ctrl_engine_t  engine clear/enable/start
- state_o  out  aes_state_t  current state, for debug/status register
- busy_o  out  1  high in every state except AES_IDLE
- done_o  out  1  one-cycle job-complete event
- err_o  out  1  one-cycle rejected-job event

Behaviour:
- Reset (rst_ni low, asynchronous):
  - state = AES_IDLE.
  - All outputs 0.
  - Latched config = 0; sticky flags = 0.
- Length check, combinational on start_i:
  - Job is valid iff length_i != 0, length_i[4:0] == 0, and length_i/32 <= MAX_BLOCKS.
  - nblocks = length_i >> 5, held in $clog2(MAX_BLOCKS)+1 bits.
- AES_IDLE:
  - start_i with a valid job: latch addr_in_i, addr_out_i, nblocks; drive ctrl_engine_o.clear=1 for this cycle; next state AES_STARTING.
  - start_i with an invalid job: err_o=1 for one cycle; stay in AES_IDLE.
- AES_STARTING:
  - Both streamer addressgen configs are driven from the latched values:
    - base_addr = addr_in (source) or addr_out (sink).
    - trans_size = line_length = nblocks*8 (32-bit words).
    - line_stride = 0, feat_length = 1, feat_stride = 0, loop_outer = 0, realign_type = 0.
  - These configs stay stable until the FSM returns to AES_IDLE.
  - When plaintext_source_flags.ready_start and chipertext_sink_flags.ready_start are both 1 in the same cycle: pulse req_start on both streamers and ctrl_engine_o.start for exactly one cycle; next state AES_WORKING.
  - Otherwise stay in AES_STARTING; no pulses.
- AES_WORKING:
  - ctrl_engine_o.enable = 1.
  - sink_done_q is set on chipertext_sink_flags.done (sticky; the flag is a pulse).
  - Exit condition: flags_engine_i.chipertext_32byte_chunck_count == nblocks AND (sink_done_q OR sink done this cycle) AND tcdm_fifo_empty → next state AES_FINISHED.
  - The exit conditions may arrive in any order or in the same cycle.
- AES_FINISHED:
  - done_o = 1 and enable = 0 for exactly one cycle.
  - sink_done_q cleared.
  - Next state AES_IDLE.
- Command handling:
  - start_i is ignored whenever state != AES_IDLE; no error is flagged.
  - clear_i has priority over all transitions in every state. Next state AES_IDLE; ctrl_engine_o.clear=1 for one cycle; sticky flags and latched config zeroed; no done_o.
  - clear_i and start_i in the same cycle: clear wins; the job is dropped.
- Latency, best case:
  - start_i at cycle 0 → AES_STARTING at cycle 1.
  - req_start/engine start at cycle 1 if both streamers are ready.
  - AES_WORKING at cycle 2.
  - done_o one cycle after the completion condition is met.

Decomposition:
- Add to aes_package:
  - AES_BLOCK_BYTES = 32 and AES_MAX_BLOCKS = 256.
  - A packed aes_job_cfg_t {addr_in, addr_out, nblocks} used for the latched config.
- aes_state_t, ctrl_/flags_ typedefs are reused unchanged.
- No sub-module: the length checker and config register stay inline. The FSM is a single two-process (state register + next-state/output logic) module.

Test Plan:
- Valid 64-byte job: length=64, addr_in=0x1000, addr_out=0x2000, streamers ready → trans_size=16 on both, req_start and engine.start pulse at cycle 1, done_o one cycle after count==2 + sink done + fifo empty; busy_o low afterwards.
- Invalid lengths 0, 33, 8224 (257 blocks) → err_o single pulse each; state stays AES_IDLE; no req_start.
- Sink ready_start held low 5 cycles → FSM remains AES_STARTING; start pulses occur only on the cycle both are ready.
- Sink done pulses 3 cycles before engine count reaches nblocks=4, with fifo non-empty 2 further cycles → done_o only after fifo empties; exactly one pulse.
- clear_i in AES_WORKING mid-job → AES_IDLE next cycle, engine.clear pulse, no done_o; a new start_i with length=32 then completes normally.
- start_i repeated while busy → ignored; no err_o; async rst_ni low mid-job → all outputs 0 immediately.
